// File: rtl/alu_mdu_seq_if.sv
// Request/response bundle of the execute unit: request handshake, flush,
// result handshake and the busy indication.
interface alu_mdu_seq_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) ();
   logic             i_flush;
   logic             i_valid;
   logic             o_ready;
   logic [4:0]       i_op;
   logic [XLEN-1:0]  i_a;
   logic [XLEN-1:0]  i_b;
   logic [TAG_W-1:0] i_tag;
   logic             o_valid;
   logic             i_ready;
   logic [XLEN-1:0]  o_res;
   logic [TAG_W-1:0] o_tag;
   logic             o_busy;

   modport slave (
      input  i_flush, i_valid, i_op, i_a, i_b, i_tag, i_ready,
      output o_ready, o_valid, o_res, o_tag, o_busy
   );

   modport master (
      output i_flush, i_valid, i_op, i_a, i_b, i_tag, i_ready,
      input  o_ready, o_valid, o_res, o_tag, o_busy
   );
endinterface

// File: rtl/alu_mdu_seq.sv
// EX-stage execute unit: single-cycle base ALU plus iterative RV32M multiply
// (radix-2 shift-add) and divide (restoring), behind valid/ready handshakes.
module alu_mdu_seq #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 5
) (
   input logic           i_clk,
   input logic           i_rst,
   alu_mdu_seq_if.slave  bus
);
   localparam int unsigned SHW = $clog2(XLEN);
   localparam int unsigned CW  = $clog2(XLEN);

   localparam logic [3:0] OP_ALU_ADD  = 4'd0;
   localparam logic [3:0] OP_ALU_SUB  = 4'd1;
   localparam logic [3:0] OP_ALU_SLL  = 4'd2;
   localparam logic [3:0] OP_ALU_SLT  = 4'd3;
   localparam logic [3:0] OP_ALU_SLTU = 4'd4;
   localparam logic [3:0] OP_ALU_XOR  = 4'd5;
   localparam logic [3:0] OP_ALU_SRL  = 4'd6;
   localparam logic [3:0] OP_ALU_SRA  = 4'd7;
   localparam logic [3:0] OP_ALU_OR   = 4'd8;
   localparam logic [3:0] OP_ALU_AND  = 4'd9;

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]  acc_q, acc_d, lo_q, lo_d, mc_q, mc_d, res_q, res_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [2:0]       fn_q, fn_d;
   logic             sa_q, sa_d, sb_q, sb_d;

   logic            accept_c, is_m_c, is_mul_c, div_zero_c, div_ovf_c, special_c;
   logic            a_neg_c, b_neg_c;
   logic [XLEN-1:0] a_mag_c, b_mag_c, alu_c, quo_c, rem_c, fix_c;
   logic [SHW-1:0]  sh_c;
   logic [XLEN:0]   mul_sum_c, div_sh_c, div_diff_c;
   logic [2*XLEN-1:0] prod_c;

   assign accept_c   = bus.i_valid & (state_q == S_IDLE) & ~bus.i_flush;
   assign is_m_c     = bus.i_op[4];
   assign is_mul_c   = ~bus.i_op[2];
   assign div_zero_c = (bus.i_b == '0);
   assign div_ovf_c  = ~bus.i_op[0] & (bus.i_a == {1'b1, {(XLEN-1){1'b0}}}) & (bus.i_b == '1);
   assign special_c  = div_zero_c | div_ovf_c;

   // Operand signedness: MULH/MULHSU treat A as signed, MULH also B; DIV/REM both.
   assign a_neg_c = bus.i_a[XLEN-1] & (is_mul_c ? (bus.i_op[1:0] == 2'd1 || bus.i_op[1:0] == 2'd2)
                                                : ~bus.i_op[0]);
   assign b_neg_c = bus.i_b[XLEN-1] & (is_mul_c ? (bus.i_op[1:0] == 2'd1) : ~bus.i_op[0]);
   assign a_mag_c = a_neg_c ? -bus.i_a : bus.i_a;
   assign b_mag_c = b_neg_c ? -bus.i_b : bus.i_b;

   always_comb begin
      sh_c  = bus.i_b[SHW-1:0];
      alu_c = '0;
      case (bus.i_op[3:0])
         OP_ALU_ADD:  alu_c = bus.i_a + bus.i_b;
         OP_ALU_SUB:  alu_c = bus.i_a - bus.i_b;
         OP_ALU_SLL:  alu_c = bus.i_a << sh_c;
         OP_ALU_SLT:  alu_c = XLEN'($signed(bus.i_a) < $signed(bus.i_b));
         OP_ALU_SLTU: alu_c = XLEN'(bus.i_a < bus.i_b);
         OP_ALU_XOR:  alu_c = bus.i_a ^ bus.i_b;
         OP_ALU_SRL:  alu_c = bus.i_a >> sh_c;
         OP_ALU_SRA:  alu_c = XLEN'($signed(bus.i_a) >>> sh_c);
         OP_ALU_OR:   alu_c = bus.i_a | bus.i_b;
         OP_ALU_AND:  alu_c = bus.i_a & bus.i_b;
         default:     alu_c = '0;
      endcase
   end

   // One iteration step of each engine; acc holds product-high / remainder.
   assign mul_sum_c  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? mc_q : '0)};
   assign div_sh_c   = {acc_q, lo_q[XLEN-1]};
   assign div_diff_c = div_sh_c - {1'b0, mc_q};

   // For multiplies sa_q already holds the product sign.
   assign prod_c = sa_q ? -{acc_q, lo_q} : {acc_q, lo_q};
   assign quo_c  = (sa_q ^ sb_q) ? -lo_q : lo_q;
   assign rem_c  = sa_q ? -acc_q : acc_q;
   assign fix_c  = fn_q[2] ? (fn_q[1] ? rem_c : quo_c)
                           : ((fn_q == 3'd0) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN]);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept_c) begin
            if (!is_m_c)        state_d = S_DONE;
            else if (is_mul_c)  state_d = S_MUL;
            else if (special_c) state_d = S_DONE;
            else                state_d = S_DIV;
         end
         S_MUL:  if (cnt_q == '0) state_d = S_FIX;
         S_DIV:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:  state_d = S_DONE;
         S_DONE: if (bus.i_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (bus.i_flush) state_d = S_IDLE;
   end

   always_comb begin
      bus.o_ready = 1'b0;
      bus.o_valid = 1'b0;
      bus.o_busy  = 1'b0;
      case (state_q)
         S_IDLE:                bus.o_ready = 1'b1;
         S_MUL, S_DIV, S_FIX:   bus.o_busy  = 1'b1;
         S_DONE:                bus.o_valid = 1'b1;
         default:               bus.o_ready = 1'b0;
      endcase
   end

   assign bus.o_res = res_q;
   assign bus.o_tag = tag_q;

   always_comb begin
      cnt_d = cnt_q;
      acc_d = acc_q;
      lo_d  = lo_q;
      mc_d  = mc_q;
      res_d = res_q;
      tag_d = tag_q;
      fn_d  = fn_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      case (state_q)
         S_IDLE: if (accept_c) begin
            tag_d = bus.i_tag;
            fn_d  = bus.i_op[2:0];
            cnt_d = CW'(XLEN - 1);
            acc_d = '0;
            lo_d  = a_mag_c;
            mc_d  = b_mag_c;
            sa_d  = is_mul_c ? (a_neg_c ^ b_neg_c) : a_neg_c;
            sb_d  = b_neg_c;
            if (!is_m_c)                     res_d = alu_c;
            else if (!is_mul_c && div_zero_c) res_d = bus.i_op[1] ? bus.i_a : '1;
            else if (!is_mul_c && div_ovf_c)  res_d = bus.i_op[1] ? '0 : bus.i_a;
         end
         S_MUL: begin
            acc_d = mul_sum_c[XLEN:1];
            lo_d  = {mul_sum_c[0], lo_q[XLEN-1:1]};
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
         end
         S_DIV: begin
            acc_d = div_diff_c[XLEN] ? div_sh_c[XLEN-1:0] : div_diff_c[XLEN-1:0];
            lo_d  = {lo_q[XLEN-2:0], ~div_diff_c[XLEN]};
            cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
         end
         S_FIX:   res_d = fix_c;
         default: cnt_d = cnt_q;
      endcase
      if (bus.i_flush) cnt_d = '0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         acc_q <= '0;
         lo_q  <= '0;
         mc_q  <= '0;
         res_q <= '0;
         tag_q <= '0;
         fn_q  <= '0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         lo_q  <= lo_d;
         mc_q  <= mc_d;
         res_q <= res_d;
         tag_q <= tag_d;
         fn_q  <= fn_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
      end
   end
endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed bench for alu_mdu_seq: vector table on 32- and 16-bit instances,
// then backpressure, flush and mid-operation reset sequences.
module tb_alu_mdu_seq;
   localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4;
   localparam logic [4:0] XOR = 5'd5, SRL = 5'd6, SRA = 5'd7, OR = 5'd8, AND = 5'd9, BAD = 5'd15;
   localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
   localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

   typedef struct {
      string       name;
      bit          w16;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   alu_mdu_seq_if #(.XLEN(32), .TAG_W(5)) b32 ();
   alu_mdu_seq_if #(.XLEN(16), .TAG_W(5)) b16 ();

   alu_mdu_seq #(.XLEN(32), .TAG_W(5)) u_dut32 (.i_clk(clk), .i_rst(rst), .bus(b32.slave));
   alu_mdu_seq #(.XLEN(16), .TAG_W(5)) u_dut16 (.i_clk(clk), .i_rst(rst), .bus(b16.slave));

   function automatic vec_t mk(string n, bit w, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                               logic [31:0] e, int l);
      vec_t v;
      v.name = n; v.w16 = w; v.op = op; v.a = a; v.b = b; v.exp = e; v.lat = l;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit w, input logic v, input logic fl, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      if (w) begin
         b16.i_valid = v; b16.i_flush = fl; b16.i_op = op;
         b16.i_a = a[15:0]; b16.i_b = b[15:0]; b16.i_tag = tag;
      end else begin
         b32.i_valid = v; b32.i_flush = fl; b32.i_op = op;
         b32.i_a = a; b32.i_b = b; b32.i_tag = tag;
      end
   endtask

   task automatic set_ready(input bit w, input logic r);
      if (w) b16.i_ready = r;
      else   b32.i_ready = r;
   endtask

   function automatic logic valid_of(bit w);
      return w ? b16.o_valid : b32.o_valid;
   endfunction
   function automatic logic [31:0] res_of(bit w);
      return w ? {16'h0, b16.o_res} : b32.o_res;
   endfunction
   function automatic logic [4:0] tag_of(bit w);
      return w ? b16.o_tag : b32.o_tag;
   endfunction

   // Issue one request, count edges until o_valid, check, then retire it.
   task automatic run_vec(input vec_t v, input logic [4:0] tag);
      int n;
      @(negedge clk);
      drive(v.w16, 1'b1, 1'b0, v.op, v.a, v.b, tag);
      @(posedge clk); #1;
      drive(v.w16, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      n = 1;
      while (!valid_of(v.w16) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk({v.name, ".lat"}, 32'(n), 32'(v.lat));
      chk({v.name, ".res"}, res_of(v.w16), v.exp);
      chk({v.name, ".tag"}, 32'(tag_of(v.w16)), 32'(tag));
      set_ready(v.w16, 1'b1);
      @(posedge clk); #1;
      set_ready(v.w16, 1'b0);
      chk({v.name, ".retire"}, 32'(valid_of(v.w16)), 32'd0);
   endtask

   initial begin
      int seen;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      set_ready(1'b0, 1'b0);
      set_ready(1'b1, 1'b0);

      vecs.push_back(mk("add_ovf", 0, ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1));
      vecs.push_back(mk("sra",     0, SRA,  32'h80000000, 32'h4,        32'hF8000000, 1));
      vecs.push_back(mk("sub",     0, SUB,  32'h5,        32'h7,        32'hFFFFFFFE, 1));
      vecs.push_back(mk("sll_msk", 0, SLL,  32'h1,        32'h3F,       32'h80000000, 1));
      vecs.push_back(mk("srl",     0, SRL,  32'h80000000, 32'h4,        32'h08000000, 1));
      vecs.push_back(mk("slt",     0, SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1));
      vecs.push_back(mk("sltu",    0, SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1));
      vecs.push_back(mk("xor",     0, XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1));
      vecs.push_back(mk("or",      0, OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1));
      vecs.push_back(mk("and",     0, AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1));
      vecs.push_back(mk("bad_op",  0, BAD,  32'h1,        32'h2,        32'h0,        1));
      vecs.push_back(mk("mulh",    0, MULH, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 34));
      vecs.push_back(mk("mul",     0, MUL,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 34));
      vecs.push_back(mk("mulhu",   0, MULHU,32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34));
      vecs.push_back(mk("mulhsu",  0, MULHSU,32'hFFFFFFFE,32'hFFFFFFFF, 32'hFFFFFFFE, 34));
      vecs.push_back(mk("div",     0, DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34));
      vecs.push_back(mk("rem",     0, REM,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34));
      vecs.push_back(mk("div_nb",  0, DIV,  32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34));
      vecs.push_back(mk("rem_nb",  0, REM,  32'h7,        32'hFFFFFFFE, 32'h1,        34));
      vecs.push_back(mk("divu",    0, DIVU, 32'd100,      32'd7,        32'd14,       34));
      vecs.push_back(mk("remu",    0, REMU, 32'd100,      32'd7,        32'd2,        34));
      vecs.push_back(mk("divu_z",  0, DIVU, 32'h7,        32'h0,        32'hFFFFFFFF, 1));
      vecs.push_back(mk("remu_z",  0, REMU, 32'h7,        32'h0,        32'h7,        1));
      vecs.push_back(mk("rem_ovf", 0, REM,  32'h80000000, 32'hFFFFFFFF, 32'h0,        1));
      vecs.push_back(mk("div_ovf", 0, DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1));
      vecs.push_back(mk("h.mulh",  1, MULH, 32'hFFFE,     32'h3,        32'hFFFF,     18));
      vecs.push_back(mk("h.mul",   1, MUL,  32'hFFFE,     32'h3,        32'hFFFA,     18));
      vecs.push_back(mk("h.mulhu", 1, MULHU,32'hFFFF,     32'hFFFF,     32'hFFFE,     18));
      vecs.push_back(mk("h.div",   1, DIV,  32'hFFF9,     32'h2,        32'hFFFD,     18));
      vecs.push_back(mk("h.rem",   1, REM,  32'hFFF9,     32'h2,        32'hFFFF,     18));
      vecs.push_back(mk("h.divu_z",1, DIVU, 32'h7,        32'h0,        32'hFFFF,     1));
      vecs.push_back(mk("h.rem_ovf",1,REM,  32'h8000,     32'hFFFF,     32'h0,        1));

      repeat (2) @(posedge clk);
      #1;
      chk("rst.ready", 32'(b32.o_ready), 32'd1);
      chk("rst.valid", 32'(b32.o_valid), 32'd0);
      chk("rst.busy",  32'(b32.o_busy),  32'd0);
      chk("rst.res",   b32.o_res,        32'd0);
      chk("rst.tag",   32'(b32.o_tag),   32'd0);
      @(negedge clk) rst = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i], 5'(i + 1));

      // Backpressure: result held, new requests ignored while in DONE.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, ADD, 32'd1, 32'd2, 5'd9);
      @(posedge clk); #1;
      chk("bp.valid", 32'(b32.o_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         drive(1'b0, 1'b1, 1'b0, SUB, 32'd100, 32'd1, 5'd3);
         @(posedge clk); #1;
         chk("bp.res",   b32.o_res,        32'd3);
         chk("bp.tag",   32'(b32.o_tag),   32'd9);
         chk("bp.ready", 32'(b32.o_ready), 32'd0);
         chk("bp.hold",  32'(b32.o_valid), 32'd1);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      set_ready(1'b0, 1'b1);
      @(posedge clk); #1;
      set_ready(1'b0, 1'b0);
      chk("bp.retire", 32'(b32.o_valid), 32'd0);
      @(posedge clk); #1;
      chk("bp.nolate", 32'(b32.o_valid), 32'd0);

      // Flush in the middle of a DIVU.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, DIVU, 32'd100, 32'd7, 5'd4);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      repeat (9) @(posedge clk);
      #1;
      chk("fl.busy", 32'(b32.o_busy), 32'd1);
      @(negedge clk) b32.i_flush = 1'b1;
      @(posedge clk); #1;
      b32.i_flush = 1'b0;
      chk("fl.valid", 32'(b32.o_valid), 32'd0);
      chk("fl.busy0", 32'(b32.o_busy),  32'd0);
      chk("fl.ready", 32'(b32.o_ready), 32'd1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (b32.o_valid) seen++;
      end
      chk("fl.noresult", 32'(seen), 32'd0);

      // Flush coinciding with a request: not accepted.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, ADD, 32'd5, 32'd5, 5'd6);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      chk("flv.valid", 32'(b32.o_valid), 32'd0);
      chk("flv.ready", 32'(b32.o_ready), 32'd1);
      run_vec(mk("fl.add", 0, ADD, 32'd20, 32'd22, 32'd42, 1), 5'd11);

      // Asynchronous reset during a multiply.
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, MUL, 32'hFFFFFFFE, 32'd3, 5'd7);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("ar.busy", 32'(b32.o_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar.busy0", 32'(b32.o_busy),  32'd0);
      chk("ar.ready", 32'(b32.o_ready), 32'd1);
      chk("ar.valid", 32'(b32.o_valid), 32'd0);
      chk("ar.res",   b32.o_res,        32'd0);
      chk("ar.tag",   32'(b32.o_tag),   32'd0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (b32.o_valid) seen++;
      end
      chk("ar.noresult", 32'(seen), 32'd0);
      run_vec(mk("ar.mul", 0, MUL, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 34), 5'd12);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
